// File: rtl/text_pkg.sv
// text_pkg: shared geometry, VRAM character entry layout and RGB helpers for the text controller.
package text_pkg;
  localparam int COLS          = 80;
  localparam int ROWS          = 30;
  localparam int WORDS_PER_ROW = 40;
  localparam int CHAR_W        = 8;
  localparam int CHAR_H        = 16;

  typedef struct packed {
    logic       invert;
    logic [6:0] code;
    logic [3:0] fg_idx;
    logic [3:0] bg_idx;
  } char_entry_t;

  // Index 0 = R, 1 = G, 2 = B.
  typedef logic [2:0][3:0] rgb_t;

  function automatic rgb_t to_rgb(input logic [11:0] c);
    return {c[3:0], c[7:4], c[11:8]};
  endfunction
endpackage

// File: rtl/text_fetch_pipeline_cursor_blink.sv
// cursor_blink: counts vsync falling edges and toggles the cursor blink phase every BLINK_FRAMES frames.
module cursor_blink #(
  parameter int BLINK_FRAMES = 32
) (
  input  logic clk_25MHz,
  input  logic reset_n,
  input  logic vsync_i,
  output logic blink_phase_o
);
  logic       vsync_q;
  logic [4:0] cnt_q, cnt_d;
  logic       fall, wrap;

  assign fall  = vsync_q & ~vsync_i;
  assign wrap  = fall && (cnt_q == 5'(BLINK_FRAMES - 1));
  assign cnt_d = wrap ? '0 : (fall ? cnt_q + 5'd1 : cnt_q);

  always_ff @(posedge clk_25MHz or negedge reset_n) begin
    if (!reset_n) begin
      vsync_q       <= 1'b0;
      cnt_q         <= '0;
      blink_phase_o <= 1'b0;
    end else begin
      vsync_q       <= vsync_i;
      cnt_q         <= cnt_d;
      blink_phase_o <= blink_phase_o ^ wrap;
    end
  end
endmodule

// File: rtl/text_fetch_pipeline.sv
// text_fetch_pipeline: two-stage VRAM character fetch, palette lookup and cursor overlay,
// aligning glyph attributes with delayed coordinates/syncs for the colour mapper.
module text_fetch_pipeline #(
  parameter int COLS         = text_pkg::COLS,
  parameter int ROWS         = text_pkg::ROWS,
  parameter int BLINK_FRAMES = 32
) (
  input  logic              clk_25MHz,
  input  logic              reset_n,
  input  logic [9:0]        drawX,
  input  logic [9:0]        drawY,
  input  logic              hsync,
  input  logic              vsync,
  input  logic              vde,
  output logic [10:0]       vram_addr,
  input  logic [31:0]       vram_rdata,
  input  logic [15:0][11:0] palette,
  input  logic [6:0]        cursor_x,
  input  logic [4:0]        cursor_y,
  input  logic              cursor_en,
  output logic [6:0]        pix_code,
  output logic              invert,
  output logic [2:0][3:0]   fg,
  output logic [2:0][3:0]   bg,
  output logic [9:0]        drawX_o,
  output logic [9:0]        drawY_o,
  output logic              hsync_o,
  output logic              vsync_o,
  output logic              vde_o
);
  import text_pkg::*;

  logic        act_in;
  logic [9:0]  x1_q, y1_q;
  logic        hs1_q, vs1_q, de1_q, act1_q;
  logic        blink_phase, hit;
  char_entry_t ent;

  assign act_in    = (drawX < 10'(COLS * CHAR_W)) && (drawY < 10'(ROWS * CHAR_H));
  assign vram_addr = act_in ? 11'(drawY[8:4]) * 11'(WORDS_PER_ROW) + 11'(drawX[9:4]) : '0;

  always_ff @(posedge clk_25MHz or negedge reset_n) begin
    if (!reset_n) begin
      x1_q   <= '0;
      y1_q   <= '0;
      hs1_q  <= 1'b0;
      vs1_q  <= 1'b0;
      de1_q  <= 1'b0;
      act1_q <= 1'b0;
    end else begin
      x1_q   <= drawX;
      y1_q   <= drawY;
      hs1_q  <= hsync;
      vs1_q  <= vsync;
      de1_q  <= vde;
      act1_q <= act_in;
    end
  end

  cursor_blink #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink (
    .clk_25MHz    (clk_25MHz),
    .reset_n      (reset_n),
    .vsync_i      (vsync),
    .blink_phase_o(blink_phase)
  );

  // Column bit 3 picks which of the two characters packed in the word is on screen.
  assign ent = x1_q[3] ? vram_rdata[31:16] : vram_rdata[15:0];
  assign hit = cursor_en && blink_phase && (x1_q[9:3] == cursor_x) && (y1_q[8:4] == cursor_y) &&
               (cursor_x < 7'(COLS)) && (cursor_y < 5'(ROWS));

  always_ff @(posedge clk_25MHz or negedge reset_n) begin
    if (!reset_n) begin
      pix_code <= '0;
      invert   <= 1'b0;
      fg       <= '0;
      bg       <= '0;
      drawX_o  <= '0;
      drawY_o  <= '0;
      hsync_o  <= 1'b0;
      vsync_o  <= 1'b0;
      vde_o    <= 1'b0;
    end else begin
      pix_code <= act1_q ? ent.code : '0;
      invert   <= act1_q & (ent.invert ^ hit);
      fg       <= act1_q ? to_rgb(palette[ent.fg_idx]) : '0;
      bg       <= act1_q ? to_rgb(palette[ent.bg_idx]) : '0;
      drawX_o  <= x1_q;
      drawY_o  <= y1_q;
      hsync_o  <= hs1_q;
      vsync_o  <= vs1_q;
      vde_o    <= de1_q;
    end
  end
endmodule

// File: tb/tb_text_fetch_pipeline.sv
// tb_text_fetch_pipeline: directed stimulus against a pixel-level reference model of the text fetch stage.
module tb_text_fetch_pipeline;
  logic              clk = 0, rst_n = 0;
  logic [9:0]        drawX = 0, drawY = 0;
  logic              hsync = 0, vsync = 0, vde = 0;
  logic [10:0]       vram_addr;
  logic [31:0]       vram_rdata = 0;
  logic [15:0][11:0] pal;
  logic [6:0]        cur_x = 5;
  logic [4:0]        cur_y = 3;
  logic              cur_en = 1;
  logic [6:0]        pix_code;
  logic              invert;
  logic [2:0][3:0]   fg, bg;
  logic [9:0]        drawX_o, drawY_o;
  logic              hsync_o, vsync_o, vde_o;

  logic [31:0] mem [1200];
  int tests = 0, fails = 0;

  typedef struct packed {
    logic [6:0]  code;
    logic        inv;
    logic [11:0] fg, bg;
    logic [9:0]  x, y;
    logic        hs, vs, de;
  } exp_t;

  exp_t h1, h2;
  int   vcnt = 0, falls = 0;
  logic prev_vs = 0;

  always #20 clk = ~clk;
  always @(posedge clk) vram_rdata <= mem[vram_addr];

  text_fetch_pipeline dut (
    .clk_25MHz(clk), .reset_n(rst_n), .drawX(drawX), .drawY(drawY),
    .hsync(hsync), .vsync(vsync), .vde(vde), .vram_addr(vram_addr), .vram_rdata(vram_rdata),
    .palette(pal), .cursor_x(cur_x), .cursor_y(cur_y), .cursor_en(cur_en),
    .pix_code(pix_code), .invert(invert), .fg(fg), .bg(bg),
    .drawX_o(drawX_o), .drawY_o(drawY_o), .hsync_o(hsync_o), .vsync_o(vsync_o), .vde_o(vde_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int exp_addr(input int x, input int y);
    return (x < 640 && y < 480) ? (y / 16) * 40 + x / 16 : 0;
  endfunction

  function automatic exp_t model(input int x, input int y, input logic hs, input logic vs,
                                 input logic de, input bit ph);
    exp_t e;
    logic [31:0] w;
    logic [15:0] en;
    bit hit;
    e = '0;
    e.x = 10'(x); e.y = 10'(y); e.hs = hs; e.vs = vs; e.de = de;
    if (x < 640 && y < 480) begin
      w   = mem[(y / 16) * 40 + x / 16];
      en  = ((x / 8) % 2 == 1) ? w[31:16] : w[15:0];
      hit = cur_en && ph && (x / 8 == int'(cur_x)) && (y / 16 == int'(cur_y)) && cur_x < 80 && cur_y < 30;
      e.code = en[14:8];
      e.inv  = en[15] ^ hit;
      e.fg   = pal[en[7:4]];
      e.bg   = pal[en[3:0]];
    end
    return e;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      vcnt = 0; falls = 0; prev_vs = 0;
    end else begin
      if (prev_vs && !vsync) falls++;
      prev_vs = vsync;
      h2 = h1;
      h1 = model(int'(drawX), int'(drawY), hsync, vsync, vde, ((falls / 32) % 2) == 1);
      vcnt++;
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) chk("vram_addr", vram_addr, exp_addr(int'(drawX), int'(drawY)));
    if (rst_n && vcnt >= 2) begin
      chk("pix_code", pix_code, h2.code);
      chk("invert", invert, h2.inv);
      chk("fg", {fg[0], fg[1], fg[2]}, h2.fg);
      chk("bg", {bg[0], bg[1], bg[2]}, h2.bg);
      chk("drawX_o", drawX_o, h2.x);
      chk("drawY_o", drawY_o, h2.y);
      chk("syncs", {hsync_o, vsync_o, vde_o}, {h2.hs, h2.vs, h2.de});
    end
  end

  task automatic step(input int x, input int y, input logic hs, input logic vs, input logic de);
    drawX = 10'(x); drawY = 10'(y); hsync = hs; vsync = vs; vde = de;
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input bit flip);
    step(44, 50, 0, 0, 1);
    step(48, 50, 0, 0, 1);
    chk("cursor_code", pix_code, 7'h15);
    chk("cursor_inv", invert, flip);
    step(700, 0, 0, 0, 0);
    step(700, 0, 0, 1, 0);
    step(700, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 1200; i++) mem[i] = $urandom;
    for (int i = 0; i < 16; i++) pal[i] = 12'($urandom);
    pal[1] = 12'hF00; pal[2] = 12'h0F0; pal[4] = 12'h00F;
    mem[0]   = 32'h2341_8A12;
    mem[122] = 32'h15A7_0000 | (mem[122] & 32'h0000_FFFF);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {pix_code, invert, fg, bg, drawX_o, drawY_o, hsync_o, vsync_o, vde_o}, 0);
    rst_n = 1;
    step(700, 0, 0, 0, 0);

    for (int i = 0; i < 18; i++) begin
      step(i < 16 ? i : 700, 0, 0, 0, i < 16);
      if (i >= 1 && i <= 16) begin
        chk("fetch_code", pix_code, (i - 1) < 8 ? 7'h0A : 7'h23);
        chk("fetch_inv", invert, (i - 1) < 8);
        chk("fetch_fg", {fg[0], fg[1], fg[2]}, (i - 1) < 8 ? 12'hF00 : 12'h00F);
        chk("fetch_bg", {bg[0], bg[1], bg[2]}, (i - 1) < 8 ? 12'h0F0 : 12'hF00);
      end
    end

    drawX = 639; drawY = 479; vde = 1;
    #1 chk("addr_last", vram_addr, 11'd1199);
    @(posedge clk); #1;
    drawX = 640; drawY = 0; vde = 0;
    #1 chk("addr_oob", vram_addr, 11'd0);
    @(posedge clk); #1;
    step(700, 0, 0, 0, 0);
    chk("oob_out", {pix_code, invert, fg, bg}, 0);

    for (int f = 0; f < 96; f++) frame(((f / 32) % 2) == 1);

    step(44, 50, 0, 0, 1);
    step(44, 50, 0, 0, 1);
    #5 rst_n = 0;
    #1 chk("async_reset", {pix_code, invert, fg, bg, drawX_o, drawY_o, hsync_o, vsync_o, vde_o}, 0);
    @(posedge clk); #1;
    chk("reset_hold", {pix_code, invert, fg, bg, drawX_o, drawY_o, hsync_o, vsync_o, vde_o}, 0);
    rst_n = 1;
    step(700, 0, 0, 0, 0);
    frame(0);

    step(700, 0, 0, 0, 0);
    cur_x = 100;
    step(700, 0, 0, 0, 0);
    for (int f = 0; f < 40; f++) frame(0);

    cur_x = 5;
    step(700, 0, 0, 0, 0);
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 799), $urandom_range(0, 524), 1'($urandom), 1'($urandom), 1'($urandom));
    step(700, 0, 0, 0, 0);
    step(700, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/text_fetch_pipeline.md
# text_fetch_pipeline

Pixel-clock stage sitting directly upstream of the colour mapper in the HDMI text controller. From the VGA timing generator's drawX/drawY, it:
- reads the packed character word from text VRAM;
- selects the 16-bit glyph entry for the current column;
- resolves the 4-bit foreground/background palette indices to 12-bit RGB;
- applies a blinking cursor.

It emits pix_code/invert/fg/bg plus delayed coordinates and syncs, all aligned for the colour mapper.

## Interface
Parameters:
- COLS, 80, character columns (640 px / 8)
- ROWS, 30, character rows (480 px / 16)
- BLINK_FRAMES, 32, frames per cursor blink half-period

Ports:
- clk_25MHz  in  1  pixel clock
- reset_n  in  1  asynchronous, active-low reset
- drawX, drawY  in  10 each  current pixel coordinate from the VGA timing generator
- hsync, vsync, vde  in  1 each  timing generator syncs and active-video flag
- vram_addr  out  11  VRAM read-port word address; combinational from drawX/drawY
- vram_rdata  in  32  VRAM read data, valid exactly 1 cycle after vram_addr
- palette  in  12 x 16  palette registers; entry bits [11:8]=R, [7:4]=G, [3:0]=B
- cursor_x  in  7  cursor column
- cursor_y  in  5  cursor row
- cursor_en  in  1  cursor enable
- pix_code  out  7  glyph code to the colour mapper
- invert  out  1  glyph invert to the colour mapper
- fg, bg  out  4 x 3 each  RGB nibbles, index 0=R, 1=G, 2=B
- drawX_o, drawY_o  out  10 each  coordinates delayed to align with the glyph outputs
- hsync_o, vsync_o, vde_o  out  1 each  syncs and active-video flag delayed to align

## Operation
- VRAM word layout: two characters per 32-bit word.
  - Bits [15:0] hold the even column; bits [31:16] hold the odd column.
  - Each 16-bit entry: [15]=invert, [14:8]=code, [7:4]=fg index, [3:0]=bg index.
- Address: vram_addr = (drawY[8:4] * 40) + drawX[9:4], 11-bit unsigned.
  - When drawX ≥ 640 or drawY ≥ 480, vram_addr = 0.
- Stage 1 registers drawX, drawY, hsync, vsync, vde and an active flag (drawX<640 && drawY<480).
- Stage 2 registers:
  - half select: drawX_s1[3] ? rdata[31:16] : rdata[15:0];
  - palette lookup of the fg and bg indices;
  - cursor hit.
- Cursor hit condition, all of:
  - cursor_en;
  - drawX_s1[9:3] == cursor_x;
  - drawY_s1[8:4] == cursor_y;
  - blink_phase = 1.
- On cursor hit: invert = entry[15] XOR 1. Otherwise invert = entry[15].
- When the stage-1 active flag is 0:
  - pix_code = 0, invert = 0;
  - fg = bg = {0,0,0};
  - vde_o follows the delayed vde.
- Blink counter:
  - 5-bit frame counter increments on each vsync falling edge, detected against the registered previous vsync.
  - On reaching BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.
- cursor_x ≥ COLS or cursor_y ≥ ROWS: the cursor never hits; no error.

## Timing
- Latency: 2 clocks from drawX/drawY/hsync/vsync/vde in to all outputs. All outputs of a given pixel change on the same edge.
- VRAM read latency is fixed at 1. No handshake; the pipeline advances every clock.
- palette, cursor_x, cursor_y and cursor_en are sampled in stage 2. A mid-frame change affects pixels from that point on; there is no tearing protection.
- Reset (async assert, synchronous-to-clock deassert handled upstream), all registers cleared:
  - outputs 0;
  - hsync_o = vsync_o = 0, vde_o = 0;
  - frame counter 0, blink_phase 0.
- Reset mid-line: outputs clear immediately. Valid pixels resume 2 clocks after the first post-reset input.
- Simultaneous vsync fall and counter wrap: a single toggle; the counter goes to 0.

## Structure
- Shared package text_pkg holds:
  - COLS, ROWS, WORDS_PER_ROW=40, CHAR_W=8, CHAR_H=16;
  - a packed struct typedef char_entry_t {invert, code[6:0], fg_idx[3:0], bg_idx[3:0]};
  - the rgb_t typedef.
- One sub-module: cursor_blink (vsync edge detector, frame counter, blink_phase output).

## Test plan
- Reset: assert reset_n=0 mid-frame -> all outputs 0 on the next edge; blink_phase 0.
- Pixel fetch:
  - Stimulus: VRAM word 0x2341_8A12 at addr 0; palette[1]=0xF00, palette[2]=0x0F0; drawX=0..15, drawY=0.
  - Cycles 2–9 (even column, low half 0x8A12): pix_code=0x0A, invert=1, fg={F,0,0}, bg={0,F,0}.
  - Cycles 10–17 (odd column, high half 0x2341): pix_code=0x23, invert=0, palette indices 4/1.
- Address arithmetic: drawX=639, drawY=479 -> vram_addr=29*40+39=1199. drawX=640 -> vram_addr=0 and 2 clocks later fg=bg=0, pix_code=0.
- Cursor blink:
  - Stimulus: cursor_en=1, cursor at (5,3); 64 vsync pulses.
  - invert is flipped at pixel (40..47, 48..63) only during frames 32–63; unflipped in frames 0–31.
- Alignment: random drawX/drawY/hsync/vsync/vde streams -> drawX_o/drawY_o/syncs equal the inputs delayed by exactly 2 clocks.
- Out-of-range cursor: cursor_x=100 -> no invert change in any frame.
